instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 10, instruction address width (1..10).
REQ-002 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 Parameter STACK_DEPTH, default 4, return-stack entries (power of two, 2..16).
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  ADDR_W  read address; equals pc while imem_req=1.
REQ-009 imem_ack  in  1  read data valid this cycle; variable latency, at least 1 cycle.
REQ-010 imem_rdata  in  16  instruction word {opcode[15:10], operand[9:0]}.
REQ-011 issue_valid  out  1  opcode/operand valid toward the decode CU.
REQ-012 issue_ready  in  1  decode side accepts the instruction.
REQ-013 opcode  out  6  issued opcode.
REQ-014 operand  out  10  issued operand (branch target, immediate or register field).
REQ-015 flags  in  4  {z,n,c,o} from the ALU; sampled only on the issue handshake.
REQ-016 pc  out  ADDR_W  address of the instruction currently fetched or issued.
REQ-017 busy  out  1  high in FETCH or ISSUE.
REQ-018 fault  out  1  sticky fault indicator.
REQ-019 fault_code  out  2  00 none, 01 illegal opcode, 10 stack overflow, 11 stack underflow.

Function
REQ-020 FSM states: IDLE, FETCH, ISSUE, FAULT; all outputs are decoded from registered state, and none is combinational from inputs.
REQ-021 IDLE: on start=1, go to FETCH next cycle; otherwise hold.
REQ-022 FETCH: imem_req=1 and imem_addr=pc; on imem_ack=1, latch imem_rdata into the instruction register.
REQ-023 FETCH: in the imem_ack cycle, if the latched opcode > 6'b011010, go to FAULT with fault_code=01; otherwise go to ISSUE.
REQ-024 Latency: imem_ack in cycle N gives issue_valid=1 in cycle N+1.
REQ-025 ISSUE: issue_valid=1; opcode and operand stay stable until the cycle in which issue_ready=1 (handshake).
REQ-026 Handshake next-PC, brz/brn/brc/bro (000000..000011): pc=operand[ADDR_W-1:0] if flags z/n/c/o respectively =1, else pc+1.
REQ-027 Handshake next-PC, bra (000110): pc=operand[ADDR_W-1:0].
REQ-028 Handshake next-PC, jmp (000111): push pc+1 onto the return stack and set pc=operand[ADDR_W-1:0].
REQ-029 Handshake next-PC, jmp with the stack full (sp==STACK_DEPTH): no push, pc unchanged, go to FAULT with fault_code=10.
REQ-030 Handshake next-PC, ret (001000): pop the top of stack into pc; with sp==0, pc is unchanged and the block goes to FAULT with fault_code=11.
REQ-031 Handshake next-PC, all other legal opcodes: pc=pc+1.
REQ-032 pc+1 wraps modulo 2^ADDR_W; the stack stores ADDR_W-bit values.
REQ-033 After a non-faulting handshake, the block returns to FETCH in the next cycle, giving one bubble cycle with imem_req=1 and issue_valid=0.
REQ-034 imem_ack is ignored outside FETCH, and issue_ready is ignored outside ISSUE.
REQ-035 FAULT: sticky until rst; imem_req=0, issue_valid=0, busy=0, fault=1; start is ignored.
REQ-036 The stack pointer sp ranges 0..STACK_DEPTH; push writes at index sp then increments; pop decrements then reads.

Reset
REQ-037 When rst=1, the block immediately enters IDLE and sets pc=RESET_PC, sp=0, imem_req=0, issue_valid=0, opcode=0, operand=0, busy=0, fault=0, fault_code=00.
REQ-038 An rst asserted during FETCH or ISSUE drops imem_req/issue_valid immediately, discards the pending instruction, and a late imem_ack after rst is ignored.

Verification
REQ-039 Reset, start, mem returns 0x2405 (add) after 2-cycle latency, ready=1 -> issue_valid one cycle after ack, opcode=001001, operand=0x005, next imem_addr=1.
REQ-040 At pc=5, brz (0x0014) with flags=1000 -> next fetch addr 0x014; repeat with flags=0000 -> next fetch addr 6.
REQ-041 Five nested jmp without ret (STACK_DEPTH=4) -> fifth handshake sets fault=1, fault_code=10; imem_req stays 0 until rst.
REQ-042 jmp at pc=3 to 0x100, then ret at 0x100 -> next fetch addr 4; a further ret -> fault_code=11.
REQ-043 Fetch of opcode 6'b111111 -> no issue_valid, fault_code=01 the cycle after ack; issue_ready held 0 for 3 cycles on a legal instruction -> opcode/operand/issue_valid stable throughout.
REQ-044 pc=0x3FF executing add -> next fetch addr 0x000; rst mid-FETCH followed by an ack -> no issue, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 16-bit words, issues {opcode, operand} to the decode CU,
// resolves branches/jumps/returns with a small return stack and traps illegal or stack faults.
module instr_fetch_unit #(
  parameter int              ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int              STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [5:0]        opcode,
  output logic [9:0]        operand,
  input  logic [3:0]        flags,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [5:0] OP_BRZ       = 6'd0;
  localparam logic [5:0] OP_BRN       = 6'd1;
  localparam logic [5:0] OP_BRC       = 6'd2;
  localparam logic [5:0] OP_BRO       = 6'd3;
  localparam logic [5:0] OP_BRA       = 6'd6;
  localparam logic [5:0] OP_JMP       = 6'd7;
  localparam logic [5:0] OP_RET       = 6'd8;
  localparam logic [5:0] OP_MAX_LEGAL = 6'd26;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_ILLEGAL   = 2'b01;
  localparam logic [1:0] FC_OVERFLOW  = 2'b10;
  localparam logic [1:0] FC_UNDERFLOW = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_FAULT} state_t;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, w_pc_nx, w_pc_inc, w_target, w_top;
  logic [SP_W-1:0]   r_sp, w_sp_dec;
  logic [5:0]        r_opcode;
  logic [9:0]        r_operand;
  logic [1:0]        r_fault_code, w_fault_code_nx;
  logic              w_push, w_pop, w_stack_full, w_stack_empty;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  assign w_pc_inc      = r_pc + 1'b1;
  assign w_target      = r_operand[ADDR_W-1:0];
  assign w_sp_dec      = r_sp - 1'b1;
  assign w_top         = r_stack[w_sp_dec[SP_W-2:0]];
  assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_stack_empty = (r_sp == '0);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_fault_code_nx = r_fault_code;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_rdata[15:10] > OP_MAX_LEGAL) begin
            w_state_nx      = S_FAULT;
            w_fault_code_nx = FC_ILLEGAL;
          end else begin
            w_state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          w_state_nx = S_FETCH;
          w_pc_nx    = w_pc_inc;
          case (r_opcode)
            OP_BRZ: if (flags[3]) w_pc_nx = w_target;
            OP_BRN: if (flags[2]) w_pc_nx = w_target;
            OP_BRC: if (flags[1]) w_pc_nx = w_target;
            OP_BRO: if (flags[0]) w_pc_nx = w_target;
            OP_BRA: w_pc_nx = w_target;
            OP_JMP: begin
              if (w_stack_full) begin
                w_pc_nx         = r_pc;
                w_state_nx      = S_FAULT;
                w_fault_code_nx = FC_OVERFLOW;
              end else begin
                w_push  = 1'b1;
                w_pc_nx = w_target;
              end
            end
            OP_RET: begin
              if (w_stack_empty) begin
                w_pc_nx         = r_pc;
                w_state_nx      = S_FAULT;
                w_fault_code_nx = FC_UNDERFLOW;
              end else begin
                w_pop   = 1'b1;
                w_pc_nx = w_top;
              end
            end
            default: ;
          endcase
        end
      end
      S_FAULT: ;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_sp         <= '0;
      r_opcode     <= '0;
      r_operand    <= '0;
      r_fault_code <= FC_NONE;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_fault_code <= w_fault_code_nx;
      if (r_state == S_FETCH && imem_ack) begin
        r_opcode  <= imem_rdata[15:10];
        r_operand <= imem_rdata[9:0];
      end
      if (w_push)     r_sp <= r_sp + 1'b1;
      else if (w_pop) r_sp <= w_sp_dec;
    end
  end

  // NOTE: the stack array is not reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[SP_W-2:0]] <= w_pc_inc;
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign issue_valid = (r_state == S_ISSUE);
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign pc          = r_pc;
  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign fault       = (r_state == S_FAULT);
  assign fault_code  = r_fault_code;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with default parameters.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, issue_ready;
  logic [15:0] imem_rdata;
  logic [3:0]  flags;
  logic        imem_req, issue_valid, busy, fault;
  logic [9:0]  imem_addr, pc, operand;
  logic [5:0]  opcode;
  logic [1:0]  fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .operand(operand), .flags(flags),
    .pc(pc), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_seen", imem_req, 1);
  endtask

  // Returns one word; ack is raised 'lat' cycles after the current FETCH cycle starts.
  task automatic ack_after(input logic [15:0] data, input int lat);
    repeat (lat - 1) step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic exec(input logic [15:0] data, input logic [3:0] f);
    flags       = f;
    issue_ready = 1'b1;
    wait_req();
    ack_after(data, 1);
    check("exec_issue_valid", issue_valid, 1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    issue_ready = 1'b0; flags = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_pc", pc, 10'h000);
    check("rst_req", imem_req, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_fcode", fault_code, 0);

    // Basic add with 2-cycle memory latency.
    issue_ready = 1'b1;
    pulse_start();
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, 10'h000);
    check("fetch_busy", busy, 1);
    ack_after(16'h2405, 2);
    check("add_valid", issue_valid, 1);
    check("add_opcode", opcode, 6'b001001);
    check("add_operand", operand, 10'h005);
    step();
    check("bubble_req", imem_req, 1);
    check("bubble_valid", issue_valid, 0);
    check("add_next_addr", imem_addr, 10'h001);

    // Conditional branches, taken and not taken.
    exec(16'h1805, 4'b0000);  check("bra_addr", imem_addr, 10'h005);
    exec(16'h0014, 4'b1000);  check("brz_taken", imem_addr, 10'h014);
    exec(16'h1805, 4'b0000);  check("bra_back", imem_addr, 10'h005);
    exec(16'h0014, 4'b0000);  check("brz_not", imem_addr, 10'h006);
    exec(16'h0440, 4'b1011);  check("brn_not", imem_addr, 10'h007);
    exec(16'h0830, 4'b0010);  check("brc_taken", imem_addr, 10'h030);
    exec(16'h0C50, 4'b0001);  check("bro_taken", imem_addr, 10'h050);

    // Issue stall: decode not ready for three cycles.
    issue_ready = 1'b0;
    wait_req();
    ack_after(16'h2C21, 1);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", issue_valid, 1);
      check("stall_opcode", opcode, 6'd11);
      check("stall_operand", operand, 10'h021);
      check("stall_req", imem_req, 0);
      step();
    end
    check("stall_hold_valid", issue_valid, 1);
    issue_ready = 1'b1;
    step();
    check("stall_next_addr", imem_addr, 10'h051);

    // Call/return and return-stack underflow.
    exec(16'h1803, 4'b0000);  check("bra_to_3", imem_addr, 10'h003);
    exec(16'h1D00, 4'b0000);  check("jmp_addr", imem_addr, 10'h100);
    exec(16'h2000, 4'b0000);  check("ret_addr", imem_addr, 10'h004);
    exec(16'h2000, 4'b0000);
    check("uflow_fault", fault, 1);
    check("uflow_code", fault_code, 2'b11);
    check("uflow_req", imem_req, 0);
    check("uflow_busy", busy, 0);
    check("uflow_pc", pc, 10'h004);
    pulse_start();
    step();
    check("fault_sticky", fault, 1);
    check("fault_start_req", imem_req, 0);

    // PC wrap, then reset in the middle of a fetch with a late ack.
    do_reset();
    check("rst2_fault", fault, 0);
    check("rst2_fcode", fault_code, 0);
    check("rst2_opcode", opcode, 0);
    pulse_start();
    exec(16'h1BFF, 4'b0000);  check("bra_3ff", imem_addr, 10'h3FF);
    exec(16'h2400, 4'b0000);  check("wrap_addr", imem_addr, 10'h000);
    exec(16'h2400, 4'b0000);  check("after_wrap", imem_addr, 10'h001);
    step();
    rst = 1'b1;
    #1;
    check("async_rst_req", imem_req, 0);
    check("async_rst_pc", pc, 10'h000);
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'h2405;
    step();
    imem_ack = 1'b0;
    step();
    check("late_ack_valid", issue_valid, 0);
    check("late_ack_busy", busy, 0);
    check("late_ack_pc", pc, 10'h000);

    // Five nested calls overflow a 4-entry stack.
    pulse_start();
    exec(16'h1C10, 4'b0000);  check("jmp1", imem_addr, 10'h010);
    exec(16'h1C20, 4'b0000);  check("jmp2", imem_addr, 10'h020);
    exec(16'h1C30, 4'b0000);  check("jmp3", imem_addr, 10'h030);
    exec(16'h1C40, 4'b0000);  check("jmp4", imem_addr, 10'h040);
    exec(16'h1C50, 4'b0000);
    check("oflow_fault", fault, 1);
    check("oflow_code", fault_code, 2'b10);
    check("oflow_pc", pc, 10'h040);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("oflow_req", imem_req, 0);
    end
    imem_ack = 1'b0;

    // Illegal opcode faults without ever issuing.
    do_reset();
    pulse_start();
    wait_req();
    ack_after(16'hFC00, 1);
    check("illegal_valid", issue_valid, 0);
    check("illegal_fault", fault, 1);
    check("illegal_code", fault_code, 2'b01);
    check("illegal_req", imem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
